sample_feeder: RTL and testbench

SAMPLE_FEEDER -- requirements
Module: sample_feeder

---
 rtl/sample_feeder_if.sv | 35 +++
 rtl/sample_feeder.sv | 152 +++++++++++++++
 tb/tb_sample_feeder.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_feeder_if.sv
// sample_feeder_if -- handshake bundle between a sample producer, the
// ping-pong frame buffer and an FFT-style frame consumer.
//
//   wr_data / wr_valid / wr_ready : producer -> buffer sample stream
//   ready                         : consumer idle, may take a new frame
//   start                         : one-cycle pulse, word 0 is on sample
//   inc                           : consumer advance, one pulse per sample
//   sample                        : current frame word (registered)
//   busy                          : a frame is being served
//   overrun                       : sticky, inc seen with no frame served
//
// The slave modport is the buffer; master is the producer/consumer side.
interface sample_feeder_if #(
  parameter int DW = 32
) ();
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic          ready;
  logic          start;
  logic          inc;
  logic [DW-1:0] sample;
  logic          busy;
  logic          overrun;

  modport slave (
    input  wr_data, wr_valid, ready, inc,
    output wr_ready, start, sample, busy, overrun
  );

  modport master (
    output wr_data, wr_valid, ready, inc,
    input  wr_ready, start, sample, busy, overrun
  );
endinterface

// File: rtl/sample_feeder.sv
// sample_feeder -- ping-pong frame buffer feeding an FFT consumer.
//
// A producer streams samples in (wr_valid/wr_ready). Two banks of N words
// alternate: while one bank is served to the consumer the other fills.
// A full bank is offered to the consumer when it signals ready; the
// consumer then steps through the frame with inc pulses and sees each word
// on the registered sample output one cycle after the request, like a
// synchronous ROM. Sample bit patterns pass through untouched.
//
// Ports:
//   clk  - sole clock, rising edge
//   rst  - synchronous, active-low reset
//   bus  - sample_feeder_if.slave (write stream + frame read side)
module sample_feeder #(
  parameter int N  = 128,
  parameter int DW = 32
) (
  input  logic           clk,
  input  logic           rst,
  sample_feeder_if.slave bus
);

  localparam int            PW   = (N > 1) ? $clog2(N) : 1;
  localparam int            AW   = PW + 1;
  localparam logic [PW-1:0] LAST = PW'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  state_t        state, state_nxt;

  logic [DW-1:0] mem [2*N];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          wbank;
  logic          rbank;
  logic [1:0]    full;
  logic [1:0]    full_nxt;

  logic [DW-1:0] sample_p1;
  logic          start_p1;
  logic          busy_r;
  logic          overrun_r;

  logic          wr_ready_w;
  logic          wr_fire;
  logic          wr_last;
  logic          launch;
  logic          adv;
  logic          frame_end;
  logic          ovr_set;
  logic [PW-1:0] rptr_inc;
  logic [AW-1:0] rd_addr;

  // Write side: a bank only accepts data while it is not full, so a bank
  // under service can never be overwritten.
  assign wr_ready_w = ~full[wbank];
  assign wr_fire    = bus.wr_valid & wr_ready_w;
  assign wr_last    = wr_fire & (wptr == LAST);

  assign rptr_inc = rptr + 1'b1;
  // Launch reads word 0; an advance reads the word after the current one.
  assign rd_addr  = launch ? {rbank, {PW{1'b0}}} : {rbank, rptr_inc};

  // Read FSM: next state and per-cycle strobes.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    adv       = 1'b0;
    frame_end = 1'b0;
    ovr_set   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.inc) ovr_set = 1'b1;
        if (full[rbank] && bus.ready) begin
          launch    = 1'b1;
          state_nxt = SERVE;
        end
      end
      SERVE: begin
        if (bus.inc) begin
          if (rptr == LAST) begin
            frame_end = 1'b1;
            state_nxt = IDLE;
          end else begin
            adv = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A bank completing on the write side and the served bank being released
  // always refer to different banks, so both updates can land together.
  always_comb begin
    full_nxt = full;
    if (wr_last)   full_nxt[wbank] = 1'b1;
    if (frame_end) full_nxt[rbank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst && wr_fire) mem[{wbank, wptr}] <= bus.wr_data;
  end

  // Stage p0 -> p1: read address resolved, registered sample and start.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr      <= '0;
      rptr      <= '0;
      wbank     <= 1'b0;
      rbank     <= 1'b0;
      full      <= 2'b00;
      start_p1  <= 1'b0;
      busy_r    <= 1'b0;
      overrun_r <= 1'b0;
      sample_p1 <= '0;
    end else begin
      full     <= full_nxt;
      start_p1 <= launch;
      if (wr_fire) wptr <= wptr + 1'b1;
      if (wr_last) wbank <= ~wbank;
      if (launch) begin
        rptr   <= '0;
        busy_r <= 1'b1;
      end else if (adv || frame_end) begin
        rptr <= rptr_inc;
      end
      if (frame_end) begin
        rbank  <= ~rbank;
        busy_r <= 1'b0;
      end
      if (ovr_set) overrun_r <= 1'b1;
      // Sample holds across frame end and idle-cycle inc pulses.
      if (launch || adv) sample_p1 <= mem[rd_addr];
    end
  end

  assign bus.wr_ready = wr_ready_w;
  assign bus.start    = start_p1;
  assign bus.sample   = sample_p1;
  assign bus.busy     = busy_r;
  assign bus.overrun  = overrun_r;

endmodule

// File: tb/tb_sample_feeder.sv
// tb_sample_feeder -- bench for sample_feeder with N=8, DW=32.
//
// The reference model tracks the buffer as a history of accepted words,
// a count of completed frames and a position within the frame in service;
// the expected sample is looked up by frame number and word index.
module tb_sample_feeder;

  localparam int N  = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  sample_feeder_if #(.DW(DW)) bus ();

  sample_feeder #(.N(N), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DW-1:0] hist [$];
  int            writes      = 0;
  int            frames_done = 0;
  int            idx         = 0;
  bit            serving     = 1'b0;
  bit            exp_start   = 1'b0;
  bit            exp_ovr     = 1'b0;
  logic [DW-1:0] exp_sample  = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven, take
  // the edge, then compare every output against the model.
  task automatic step();
    int full_cnt;
    bit acc;
    full_cnt = (writes / N) - frames_done;
    acc      = bus.wr_valid && (full_cnt < 2);
    if (!rst) begin
      hist.delete();
      writes      = 0;
      frames_done = 0;
      idx         = 0;
      serving     = 1'b0;
      exp_start   = 1'b0;
      exp_ovr     = 1'b0;
      exp_sample  = '0;
    end else begin
      exp_start = 1'b0;
      if (serving) begin
        if (bus.inc) begin
          if (idx == N - 1) begin
            serving = 1'b0;
            frames_done++;
          end else begin
            idx++;
            exp_sample = hist[frames_done * N + idx];
          end
        end
      end else begin
        if (bus.inc) exp_ovr = 1'b1;
        if (full_cnt > 0 && bus.ready) begin
          serving    = 1'b1;
          idx        = 0;
          exp_sample = hist[frames_done * N];
          exp_start  = 1'b1;
        end
      end
      if (acc) begin
        hist.push_back(bus.wr_data);
        writes++;
      end
    end
    @(posedge clk);
    #1;
    chk("wr_ready", bus.wr_ready, (((writes / N) - frames_done) < 2) ? 1 : 0);
    chk("start",    bus.start,    exp_start);
    chk("busy",     bus.busy,     serving);
    chk("sample",   bus.sample,   exp_sample);
    chk("overrun",  bus.overrun,  exp_ovr);
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    step();
    bus.wr_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    for (int i = 0; i < 10 && bus.start !== 1'b1; i++) step();
    chk(tag, bus.start, 1);
  endtask

  task automatic serve_frame();
    for (int k = 0; k < N; k++) begin
      bus.inc = 1'b1;
      step();
    end
    bus.inc = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  logic [DW-1:0] first_w;
  int            frames_seen;
  int            cyc;
  bit            busy_prev;
  int            base;

  initial begin
    bus.wr_data  = '0;
    bus.wr_valid = 1'b0;
    bus.ready    = 1'b0;
    bus.inc      = 1'b0;

    // Reset state
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    chk("rst_wr_ready", bus.wr_ready, 1);
    chk("rst_busy",     bus.busy,     0);
    chk("rst_sample",   bus.sample,   0);

    // inc with no frame in service: sticky overrun, sample untouched
    bus.inc = 1'b1;
    step();
    bus.inc = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("ovr_sticky", bus.overrun, 1);
    chk("ovr_sample", bus.sample,  0);
    do_reset();
    chk("ovr_cleared", bus.overrun, 0);

    // Single frame of ascending float patterns
    bus.ready = 1'b1;
    for (int k = 0; k < N; k++) write_word(32'h3F80_0000 + k);
    wait_start("start_f0");
    chk("f0_word0", bus.sample, 32'h3F80_0000);
    for (int k = 0; k < N; k++) begin
      bus.inc = 1'b1;
      step();
      if (k < N - 1) chk("f0_word", bus.sample, 32'h3F80_0000 + k + 1);
    end
    bus.inc = 1'b0;
    chk("f0_busy_end", bus.busy, 0);
    chk("f0_hold", bus.sample, 32'h3F80_0007);

    // Two banks filled with consumer not ready, then served back to back
    bus.ready = 1'b0;
    for (int k = 0; k < 2 * N; k++) write_word(32'h4000_0000 + k);
    chk("both_full_wr_ready", bus.wr_ready, 0);
    step();
    chk("no_start_unready", bus.start, 0);
    bus.ready = 1'b1;
    wait_start("start_b2b_a");
    chk("b2b_a_word0", bus.sample, 32'h4000_0000);
    serve_frame();
    chk("gap_busy",  bus.busy,  0);
    chk("gap_start", bus.start, 0);
    step();
    chk("start_b2b_b", bus.start, 1);
    chk("b2b_b_word0", bus.sample, 32'h4000_0008);
    serve_frame();

    // Refill of the idle bank completes on the same edge the frame ends
    for (int k = 0; k < N; k++) write_word(32'h5000_0000 + k);
    wait_start("start_ov_a");
    first_w = 32'h6000_0000;
    for (int k = 0; k < N; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = first_w + k;
      bus.inc      = 1'b1;
      step();
    end
    bus.wr_valid = 1'b0;
    bus.inc      = 1'b0;
    chk("ov_busy_end", bus.busy,     0);
    chk("ov_wr_ready", bus.wr_ready, 1);
    step();
    chk("ov_start_b",  bus.start,  1);
    chk("ov_b_word0",  bus.sample, first_w);
    serve_frame();

    // Reset in the middle of a frame discards everything buffered
    for (int k = 0; k < N; k++) write_word(32'h7000_0000 + k);
    wait_start("start_mid");
    for (int k = 0; k < 3; k++) begin
      bus.inc = 1'b1;
      step();
    end
    bus.inc = 1'b0;
    chk("mid_word3", bus.sample, 32'h7000_0003);
    do_reset();
    chk("mid_busy",     bus.busy,     0);
    chk("mid_wr_ready", bus.wr_ready, 1);
    for (int k = 0; k < N - 1; k++) write_word(32'h8000_0000 + k);
    for (int i = 0; i < 3; i++) step();
    chk("mid_no_start", bus.start, 0);
    chk("mid_no_busy",  bus.busy,  0);
    write_word(32'h8000_0007);
    wait_start("start_after_rst");
    chk("after_rst_word0", bus.sample, 32'h8000_0000);
    serve_frame();

    // Random producer and consumer gaps over 100 frames
    frames_seen = 0;
    busy_prev   = bus.busy;
    base        = frames_done;
    cyc         = 0;
    while (cyc < 20000 && frames_seen < 100) begin
      bus.wr_valid = ($urandom % 4) != 0;
      bus.wr_data  = $urandom;
      bus.ready    = ($urandom % 8) != 0;
      bus.inc      = serving && (($urandom % 3) != 0);
      step();
      if (busy_prev && !bus.busy) frames_seen++;
      busy_prev = bus.busy;
      cyc++;
    end
    bus.wr_valid = 1'b0;
    bus.inc      = 1'b0;
    chk("rand_frames", frames_seen, 100);
    chk("rand_model_frames", frames_done - base, frames_seen);
    chk("rand_overrun", bus.overrun, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
